axis_rr_switch: RTL

//  N-to-1 AXI-Stream switch with registered round-robin arbitration. Merges NUM_INPUTS

---
 rtl/axis_rr_switch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/axis_rr_switch.sv
// axis_rr_switch
//   N-to-1 AXI-Stream switch with registered round-robin arbitration. The
//   granted input owns the output until its TLAST beat (PACKET_MODE=1) or until
//   IDLE_TIMEOUT consecutive cycles without TVALID (PACKET_MODE=0). Every release
//   passes through one IDLE cycle before the next grant is made.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   AXIS_IN_TDATA     NUM_INPUTS packed channels, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   AXIS_IN_TVALID    per-channel valid
//   AXIS_IN_TLAST     per-channel last
//   AXIS_IN_TREADY    per-channel ready (only the granted channel sees downstream ready)
//   AXIS_OUT_TDATA    granted channel's data, zero while idle
//   AXIS_OUT_TVALID   granted channel's valid, zero while idle
//   AXIS_OUT_TLAST    granted channel's last, zero while idle
//   AXIS_OUT_TID      index of the granted channel, zero while idle
//   AXIS_OUT_TREADY   downstream ready
//   locked            high while a channel holds the grant
module axis_rr_switch #(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned NUM_INPUTS   = 4,
  parameter bit          PACKET_MODE  = 1'b0,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   AXIS_IN_TDATA,
  input  logic [NUM_INPUTS-1:0]              AXIS_IN_TVALID,
  input  logic [NUM_INPUTS-1:0]              AXIS_IN_TLAST,
  output logic [NUM_INPUTS-1:0]              AXIS_IN_TREADY,
  output logic [DATA_WIDTH-1:0]              AXIS_OUT_TDATA,
  output logic                               AXIS_OUT_TVALID,
  output logic                               AXIS_OUT_TLAST,
  output logic [$clog2(NUM_INPUTS)-1:0]      AXIS_OUT_TID,
  input  logic                               AXIS_OUT_TREADY,
  output logic                               locked
);

  localparam int unsigned IDW          = $clog2(NUM_INPUTS);
  localparam logic [15:0] TIMEOUT_LAST = 16'(IDLE_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  last_grant;
  logic [15:0]     idle_cnt;

  logic [IDW-1:0]  pick;
  logic            any_valid;
  logic            g_valid;
  logic            g_last;
  logic [DATA_WIDTH-1:0] g_data;

  // Round-robin pick: first requesting channel after last_grant, wrapping.
  always_comb begin
    logic           found;
    logic [IDW-1:0] cand;
    int unsigned    idx;
    pick      = '0;
    found     = 1'b0;
    cand      = '0;
    idx       = 0;
    any_valid = |AXIS_IN_TVALID;
    for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
      idx  = (32'(last_grant) + k) % NUM_INPUTS;
      cand = IDW'(idx);
      if (!found && AXIS_IN_TVALID[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    g_valid = AXIS_IN_TVALID[grant];
    g_last  = AXIS_IN_TLAST[grant];
    g_data  = AXIS_IN_TDATA[grant*DATA_WIDTH +: DATA_WIDTH];
  end

  // Output mux is combinational from the registered grant; because reset clears
  // state asynchronously, every output drops in the same cycle reset rises.
  always_comb begin
    AXIS_IN_TREADY  = '0;
    AXIS_OUT_TDATA  = '0;
    AXIS_OUT_TVALID = 1'b0;
    AXIS_OUT_TLAST  = 1'b0;
    AXIS_OUT_TID    = '0;
    locked          = 1'b0;
    if (state == LOCKED) begin
      AXIS_IN_TREADY[grant] = AXIS_OUT_TREADY;
      AXIS_OUT_TDATA        = g_data;
      AXIS_OUT_TVALID       = g_valid;
      AXIS_OUT_TLAST        = g_last;
      AXIS_OUT_TID          = grant;
      locked                = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDW'(NUM_INPUTS - 1);
      idle_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant      <= pick;
            last_grant <= pick;
            idle_cnt   <= '0;
            state      <= LOCKED;
          end
        end
        LOCKED: begin
          if (PACKET_MODE) begin
            if (g_valid && AXIS_OUT_TREADY && g_last)
              state <= IDLE;
          end else begin
            // Backpressured beats still count as activity, so only TVALID matters.
            if (g_valid) begin
              idle_cnt <= '0;
            end else if (idle_cnt == TIMEOUT_LAST) begin
              idle_cnt <= '0;
              state    <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
